key_poll_master: RTL and testbench

Avalon-MM read-only master that periodically polls a PIO input slave (the push-button PIO on the Tetris SoC fabric) for its 32-bit data register. It debounces the selected key bits in hardware and presents a clean per-key level plus one-cycle press pulses to the game logic. The NIOS CPU no longer needs to poll the buttons. It sits beside the CPU as a second master on the same Avalon interconnect.

---
 rtl/key_poll_pkg.sv | 20 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/key_poll_master.sv | 171 +++++++++++++++++
 tb/tb_key_poll_master.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_poll_pkg.sv
// -----------------------------------------------------------------------------
// key_poll_pkg
//   Shared types and constants for the key poll master.
//   - poll_state_e : poll FSM encoding (IDLE, REQ, WAIT_DATA, UPDATE)
//   - DEB_CNT_W    : width of each key's debounce counter
//   - AVM_DATA_W   : Avalon-MM read data width
// -----------------------------------------------------------------------------
package key_poll_pkg;

  localparam int AVM_DATA_W = 32;
  localparam int DEB_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    UPDATE
  } poll_state_e;

endpackage : key_poll_pkg

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Per-key debouncer. Each step compares the new sample with the stable
//   level; DEBOUNCE_SAMPLES consecutive differing samples flip the level.
//   Any sample that agrees with the stable level restarts the count.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   step     in   one-cycle strobe: evaluate `sample` this cycle
//   sample   in   polarity-corrected key sample, 1 = pressed
//   stable   out  debounced level, 1 = pressed
//   press    out  one-cycle pulse when `stable` rises
// -----------------------------------------------------------------------------
module key_debounce
  import key_poll_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic step,
  input  logic sample,
  output logic stable,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] TARGET = DEB_CNT_W'(DEBOUNCE_SAMPLES);

  logic [DEB_CNT_W-1:0] cnt;
  logic [DEB_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + DEB_CNT_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (step) begin
        if (sample == stable) begin
          cnt <= '0;
        end else if (cnt_inc == TARGET) begin
          stable <= sample;
          cnt    <= '0;
          // Only a 0->1 flip pulses; a release flips with sample = 0.
          press  <= sample;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule : key_debounce

// File: rtl/key_poll_master.sv
// -----------------------------------------------------------------------------
// key_poll_master
//   Avalon-MM read-only master that periodically reads the push-button PIO
//   data register, debounces the low NUM_KEYS bits and presents a clean
//   per-key level plus one-cycle press pulses.
//
//   Optional feature macro: KEY_POLL_IRQ_EN
//     When defined, adds `irq` (set on any press, cleared by `irq_ack`) and
//     `irq_ack`. When undefined neither port nor any irq logic exists.
//
// Ports:
//   clk                in   system clock
//   reset_n            in   asynchronous active-low reset
//   avm_address        out  constant BASE_ADDR
//   avm_read           out  read request, held until accepted
//   avm_readdata       in   read data (bits above NUM_KEYS-1 ignored)
//   avm_waitrequest    in   slave stall
//   avm_readdatavalid  in   readdata qualifier (ignored outside WAIT_DATA)
//   key_state          out  debounced level per key, 1 = pressed
//   key_press          out  one-cycle pulse per key on debounced press
//   busy               out  high while a read is outstanding
//   irq                out  (KEY_POLL_IRQ_EN only) sticky press interrupt
//   irq_ack            in   (KEY_POLL_IRQ_EN only) interrupt acknowledge
// -----------------------------------------------------------------------------
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int ADDR_W           = 4,
  parameter int BASE_ADDR        = 0,
  parameter int NUM_KEYS         = 2,
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 8,
  parameter bit KEY_ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic                  busy
`ifdef KEY_POLL_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_ack
`endif
);

  localparam int TIMER_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);

  poll_state_e           state;
  logic [TIMER_W-1:0]    timer;
  logic                  tick;
  logic                  pending;
  logic [NUM_KEYS-1:0]   raw;
  logic [NUM_KEYS-1:0]   sample;
  logic                  update_step;

  // Only the low NUM_KEYS bits matter; the rest of the bus is deliberately
  // left unconnected to any logic.
  logic [AVM_DATA_W-1:0] unused_readdata;
  assign unused_readdata = avm_readdata;

  assign avm_address = ADDR_W'(BASE_ADDR);

  // ---------------------------------------------------------------------------
  // Free-running poll tick timer
  // ---------------------------------------------------------------------------
  assign tick = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Poll FSM with registered bus outputs. `pending` lives here so that the
  // tick (set) and the IDLE hand-off (clear) have a single driver.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      avm_read <= 1'b0;
      busy     <= 1'b0;
      raw      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            pending  <= 1'b0;
            avm_read <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // avm_read/avm_address hold until the slave stops stalling.
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (avm_readdatavalid) begin
            raw   <= avm_readdata[NUM_KEYS-1:0];
            busy  <= 1'b0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // NOTE: the last non-blocking assignment in a block wins, so a tick on
      // the same edge as the IDLE clear keeps `pending` set; a tick while
      // already pending simply leaves it at 1 (extra ticks are dropped).
      if (tick) begin
        pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: one step per completed poll
  // ---------------------------------------------------------------------------
  assign update_step = (state == UPDATE);
  assign sample      = raw ^ {NUM_KEYS{KEY_ACTIVE_LOW}};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .step   (update_step),
      .sample (sample[g]),
      .stable (key_state[g]),
      .press  (key_press[g])
    );
  end

`ifdef KEY_POLL_IRQ_EN
  // ---------------------------------------------------------------------------
  // Press interrupt: a new press outranks a simultaneous acknowledge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (|key_press) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule : key_poll_master

// File: tb/tb_key_poll_master.sv
// -----------------------------------------------------------------------------
// tb_key_poll_master
//   Self-checking bench for key_poll_master (POLL_CYCLES=4,
//   DEBOUNCE_SAMPLES=3, two active-low keys). A latency-1 Avalon slave model
//   with programmable waitrequest stalls serves reads; every delivered word is
//   run through a reference debouncer whose expected key_state/key_press is
//   queued and compared on the DUT's UPDATE edge. Define KEY_POLL_IRQ_EN to
//   also exercise the interrupt.
// -----------------------------------------------------------------------------
module tb_key_poll_master;

  localparam int ADDR_W    = 4;
  localparam int BASE_ADDR = 10;
  localparam int NUM_KEYS  = 2;
  localparam int POLL_CYC  = 4;
  localparam int DEB       = 3;

  typedef struct packed {
    logic [NUM_KEYS-1:0] state;
    logic [NUM_KEYS-1:0] press;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic [31:0]         avm_readdata = '0;
  logic                avm_waitrequest = 1'b0;
  logic                avm_readdatavalid = 1'b0;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic                busy;
`ifdef KEY_POLL_IRQ_EN
  logic                irq;
  logic                irq_ack;
`endif

  int checks = 0;
  int errors = 0;

  // Slave model controls
  bit          slave_en  = 1'b1;
  int          wait_cfg  = 0;
  int          stall_cnt = 0;
  bit          accepted  = 1'b0;
  logic [31:0] slave_data = 32'h3;
  bit          inj_rdv   = 1'b0;
  logic [31:0] inj_data  = '0;
  int          polls_done = 0;

  // Reference model and scoreboard
  logic [NUM_KEYS-1:0] m_stable = '0;
  int                  m_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] exp_state_now = '0;
  exp_t                sb_q [$];
  int                  sb_wait = 0;

  key_poll_master #(
    .ADDR_W          (ADDR_W),
    .BASE_ADDR       (BASE_ADDR),
    .NUM_KEYS        (NUM_KEYS),
    .POLL_CYCLES     (POLL_CYC),
    .DEBOUNCE_SAMPLES(DEB),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .key_state        (key_state),
    .key_press        (key_press),
    .busy             (busy)
`ifdef KEY_POLL_IRQ_EN
    ,
    .irq              (irq),
    .irq_ack          (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  // Random upper bits check that only the low NUM_KEYS bits are used.
  function automatic logic [31:0] mk_data(input logic [NUM_KEYS-1:0] keys);
    logic [31:0] r;
    r = $urandom();
    return {r[31:NUM_KEYS], keys};
  endfunction

  function automatic void model_poll(input logic [31:0] d);
    exp_t e;
    logic s;
    e.press = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      s = ~d[k];
      if (s == m_stable[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] + 1 == DEB) begin
        m_stable[k] = s;
        m_cnt[k]    = 0;
        e.press[k]  = s;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    e.state = m_stable;
    sb_q.push_back(e);
    sb_wait = 2;
  endfunction

  function automatic void reset_model();
    m_stable      = '0;
    exp_state_now = '0;
    for (int k = 0; k < NUM_KEYS; k++) m_cnt[k] = 0;
    sb_q.delete();
    sb_wait = 0;
  endfunction

  // Latency-1 slave, driven on the falling edge.
  always @(negedge clk) begin
    if (!slave_en) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = inj_rdv;
      avm_readdata      = inj_data;
      accepted          = 1'b0;
      stall_cnt         = 0;
    end else begin
      avm_readdatavalid = 1'b0;
      if (accepted) begin
        accepted          = 1'b0;
        avm_readdata      = slave_data;
        avm_readdatavalid = 1'b1;
        model_poll(slave_data);
        polls_done++;
      end
      if (avm_read) begin
        if (stall_cnt < wait_cfg) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt       = 0;
          accepted        = 1'b1;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pop on the UPDATE edge, otherwise key outputs hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n) begin
      if (sb_wait == 1) begin
        sb_wait = 0;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: update edge with empty expected queue at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          if (key_state !== e.state || key_press !== e.press) begin
            errors++;
            $display("FAIL sb_update: key_state=%b key_press=%b, expected state=%b press=%b at %0t",
                     key_state, key_press, e.state, e.press, $time);
          end
          exp_state_now = e.state;
        end
      end else begin
        if (sb_wait == 2) sb_wait = 1;
        checks++;
        if (key_press !== '0 || key_state !== exp_state_now) begin
          errors++;
          $display("FAIL sb_hold: key_state=%b key_press=%b, expected state=%b press=00 at %0t",
                   key_state, key_press, exp_state_now, $time);
        end
      end
    end
  end

  // Wait for n more delivered words, returning just after their UPDATE edge.
  task automatic wait_polls(input int n);
    int target = polls_done + n;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (polls_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_polls: got %0d polls, expected %0d within budget", polls_done, target);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string name, input logic [NUM_KEYS-1:0] exp);
    checks++;
    if (key_state !== exp) begin
      errors++;
      $display("FAIL %s: key_state=%b, expected %b", name, key_state, exp);
    end
  endtask

  // Release reset (optionally with a stray readdatavalid on the first edge)
  // and check the first read appears after the 5th rising edge.
  task automatic release_and_check(input bit stray);
    int first = 0;
    @(posedge clk);
    #1;
    if (stray) begin
      inj_data = '0;
      inj_rdv  = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        inj_rdv  = 1'b0;
        slave_en = 1'b1;
      end
      if (avm_read) begin
        first = i;
        break;
      end
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL first_read: avm_read first high at edge %0d, expected 5", first);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || key_state !== '0 || key_press !== '0) begin
      errors++;
      $display("FAIL reset_outputs: read=%b busy=%b state=%b press=%b, expected all 0",
               avm_read, busy, key_state, key_press);
    end
    checks++;
    if (avm_address !== ADDR_W'(BASE_ADDR)) begin
      errors++;
      $display("FAIL reset_address: avm_address=%h, expected %h", avm_address, ADDR_W'(BASE_ADDR));
    end
`ifdef KEY_POLL_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: irq=%b, expected 0", irq);
    end
`endif
    release_and_check(1'b0);
  endtask

  task automatic test_poll_period();
    int  last_rise = -1;
    int  rises = 0;
    bit  prev;
    slave_data = mk_data(2'b11);
    prev = avm_read;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (avm_read && !prev) begin
        if (last_rise >= 0) begin
          checks++;
          if (i - last_rise != POLL_CYC) begin
            errors++;
            $display("FAIL poll_spacing: gap %0d, expected %0d", i - last_rise, POLL_CYC);
          end
        end
        last_rise = i;
        rises++;
      end
      if (last_rise >= 0 && i == last_rise + 1) begin
        checks++;
        if (avm_read !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL read_pulse: read=%b busy=%b after accept, expected 0/1", avm_read, busy);
        end
      end
      if (last_rise >= 0 && i == last_rise + 2) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_drop: busy=%b in UPDATE, expected 0", busy);
        end
      end
      prev = avm_read;
    end
    checks++;
    if (rises != 10) begin
      errors++;
      $display("FAIL poll_count: %0d reads in 40 cycles, expected 10", rises);
    end
    expect_state("idle_keys", 2'b00);
  endtask

  task automatic test_press();
    slave_data = mk_data(2'b10);
    wait_polls(2);
    expect_state("press_pre", 2'b00);
    wait_polls(1);
    expect_state("press_state", 2'b01);
    checks++;
    if (key_press !== 2'b01) begin
      errors++;
      $display("FAIL press_pulse: key_press=%b, expected 01", key_press);
    end
    @(posedge clk);
    #2;
    checks++;
    if (key_press !== 2'b00) begin
      errors++;
      $display("FAIL press_width: key_press=%b one cycle later, expected 00", key_press);
    end
    slave_data = mk_data(2'b11);
    wait_polls(3);
    expect_state("release_state", 2'b00);
  endtask

  task automatic test_glitch();
    slave_data = mk_data(2'b10);
    wait_polls(2);
    slave_data = mk_data(2'b11);
    wait_polls(1);
    expect_state("glitch_1", 2'b00);
    slave_data = mk_data(2'b10);
    wait_polls(2);
    expect_state("glitch_2", 2'b00);
    slave_data = mk_data(2'b11);
    wait_polls(1);
  endtask

  task automatic test_stall();
    int  hi = 0;
    int  gap = 0;
    bit  stable_ok = 1'b1;
    bit  seen = 1'b0;
    wait_cfg = 10;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (avm_read) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_start: avm_read=0, expected a read within 20 cycles");
    end
    while (avm_read && hi < 40) begin
      hi++;
      if (avm_address !== ADDR_W'(BASE_ADDR) || busy !== 1'b1) stable_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_cfg = 0;
    checks++;
    if (hi != 11 || !stable_ok) begin
      errors++;
      $display("FAIL stall_hold: read held %0d cycles stable=%0b, expected 11 stable=1", hi, stable_ok);
    end
    for (int g = 1; g <= 20; g++) begin
      @(posedge clk);
      #1;
      if (avm_read) begin
        gap = g;
        break;
      end
    end
    checks++;
    if (gap != 3) begin
      errors++;
      $display("FAIL stall_reissue: next read after %0d edges, expected 3", gap);
    end
    gap = 0;
    for (int g = 1; g <= 20; g++) begin
      @(posedge clk);
      #1;
      if (avm_read) begin
        gap = g;
        break;
      end
    end
    checks++;
    if (gap != 4) begin
      errors++;
      $display("FAIL stall_resume: following read after %0d edges, expected 4", gap);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    slave_data = mk_data(2'b00);
    wait_polls(3);
    expect_state("both_pressed", 2'b11);
    slave_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (avm_read) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!seen || avm_read !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_data: seen=%0b read=%b busy=%b, expected 1/0/1", seen, avm_read, busy);
    end
    @(negedge clk);
    reset_n = 1'b0;
    reset_model();
    #1;
    checks++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || key_state !== '0 || key_press !== '0) begin
      errors++;
      $display("FAIL mid_reset: read=%b busy=%b state=%b press=%b, expected all 0",
               avm_read, busy, key_state, key_press);
    end
`ifdef KEY_POLL_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_irq: irq=%b, expected 0", irq);
    end
`endif
    repeat (2) @(posedge clk);
    release_and_check(1'b1);
    slave_data = mk_data(2'b00);
    wait_polls(2);
    expect_state("stray_ignored", 2'b00);
    wait_polls(1);
    expect_state("after_reset_press", 2'b11);
  endtask

`ifdef KEY_POLL_IRQ_EN
  task automatic test_irq();
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b after press, expected 1", irq);
    end
    @(negedge clk);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack: irq=%b after ack, expected 0", irq);
    end
    slave_data = mk_data(2'b11);
    wait_polls(3);
    slave_data = mk_data(2'b01);
    wait_polls(3);
    expect_state("key1_press", 2'b10);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_key1: irq=%b after key1 press, expected 1", irq);
    end
    @(negedge clk);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    slave_data = mk_data(2'b11);
    wait_polls(3);
    slave_data = mk_data(2'b01);
    wait_polls(3);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_coincident: irq=%b with press and ack together, expected 1", irq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_held_ack: irq=%b with ack and no press, expected 0", irq);
    end
    irq_ack = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef KEY_POLL_IRQ_EN
    irq_ack = 1'b0;
`endif
    reset_model();
    test_reset();
    test_poll_period();
    test_press();
    test_glitch();
    test_stall();
    test_reset_mid();
`ifdef KEY_POLL_IRQ_EN
    test_irq();
`endif
    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_poll_master
